// File: rtl/float_pkg.sv
// Shared FP32 definitions for the float multiply/divide datapaths: field widths,
// bias, canonical special encodings and the sequencer state type.
package float_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int          EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    // Significand with hidden bit; a zero exponent field (zero or denormal) yields 0.
    function automatic logic [MAN_W:0] unpack_mant(input logic [31:0] x);
        return (|x[30:23]) ? {1'b1, x[MAN_W-1:0]} : '0;
    endfunction

endpackage

// File: rtl/float_round_rne.sv
// Combinational normalise/round/pack of a 48-bit significand product into FP32:
// round-to-nearest-even, overflow to Inf, underflow flushed to signed zero.
module float_round_rne
    import float_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [47:0]       prod,
    output logic [31:0]       result
);

    logic [23:0]       mant;
    logic              g, r, s, up;
    logic [24:0]       mr;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_out;
    logic [22:0]       frac;

    always_comb begin
        if (prod[47]) begin
            mant   = prod[47:24];
            g      = prod[23];
            r      = prod[22];
            s      = |prod[21:0];
            e_norm = exp_in + 10'sd1;
        end else begin
            mant   = prod[46:23];
            g      = prod[22];
            r      = prod[21];
            s      = |prod[20:0];
            e_norm = exp_in;
        end

        up = g & (r | s | mant[0]);
        mr = {1'b0, mant} + {24'd0, up};

        // Carry out of rounding means the significand became exactly 2.0.
        if (mr[24]) begin
            e_out = e_norm + 10'sd1;
            frac  = mr[23:1];
        end else begin
            e_out = e_norm;
            frac  = mr[22:0];
        end

        if (prod[47:46] == 2'b00)
            result = {sign, 31'h0};
        else if (e_out >= 10'sd255)
            result = {sign, POS_INF[30:0]};
        else if (e_out <= 10'sd0)
            result = {sign, 31'h0};
        else
            result = {sign, e_out[7:0], frac};
    end

endmodule

// File: rtl/float_mul_seq.sv
// Multi-cycle FP32 multiplier, radix-2^BITS_PER_CYCLE shift-add, valid/ready handshake.
// Define FLOAT_MUL_SPECIAL_EN to decode NaN/Inf/zero operands on a 1-cycle fast path.
module float_mul_seq
    import float_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] C
);

    localparam int unsigned K   = BITS_PER_CYCLE;
    localparam int unsigned N   = 24 / K;
    localparam int unsigned PW  = 48 + K;
    localparam int unsigned PPW = 24 + K;

    state_t            state;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [23:0]       mant_a;
    logic [23:0]       mant_b;
    logic [PW-1:0]     acc;
    logic [4:0]        cnt;

    logic [PPW-1:0]    pp;
    logic [PW-1:0]     acc_next;
    logic signed [9:0] exp_sum;
    logic [31:0]       rounded;

    // Each slice's partial product enters at bit 24 and is shifted down, so the
    // accumulator carries K spare bits above the 48-bit product.
    always_comb begin
        pp       = PPW'(mant_a) * PPW'(mant_b[K-1:0]);
        acc_next = (acc + {pp, 24'h0}) >> K;
        exp_sum  = $signed({2'b00, A[30:23]}) + $signed({2'b00, B[30:23]}) - 10'sd127;
    end

`ifdef FLOAT_MUL_SPECIAL_EN
    logic        spec_hit;
    logic [31:0] spec_val;
    logic        spec_r;
    logic [31:0] spec_c;

    always_comb begin
        logic a_max, b_max, a_zero, b_zero, a_nan, b_nan, sgn;
        a_max  = &A[30:23];
        b_max  = &B[30:23];
        a_zero = ~|A[30:23];
        b_zero = ~|B[30:23];
        a_nan  = a_max & (|A[22:0]);
        b_nan  = b_max & (|B[22:0]);
        sgn    = A[31] ^ B[31];
        spec_hit = a_max | b_max | a_zero | b_zero;
        if (a_nan | b_nan | (a_max & b_zero) | (b_max & a_zero))
            spec_val = QNAN;
        else if (a_max | b_max)
            spec_val = {sgn, POS_INF[30:0]};
        else
            spec_val = {sgn, 31'h0};
    end
`endif

    float_round_rne u_round (
        .sign   (sign_r),
        .exp_in (exp_r),
        .prod   (acc[47:0]),
        .result (rounded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            C         <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mant_a    <= '0;
            mant_b    <= '0;
            acc       <= '0;
            cnt       <= '0;
`ifdef FLOAT_MUL_SPECIAL_EN
            spec_r    <= 1'b0;
            spec_c    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_r   <= A[31] ^ B[31];
                        exp_r    <= exp_sum;
                        mant_a   <= unpack_mant(A);
                        mant_b   <= unpack_mant(B);
                        acc      <= '0;
                        cnt      <= '0;
`ifdef FLOAT_MUL_SPECIAL_EN
                        spec_r   <= spec_hit;
                        spec_c   <= spec_val;
                        state    <= spec_hit ? NORM : MUL;
`else
                        state    <= MUL;
`endif
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mant_b <= mant_b >> K;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'(N - 1))
                        state <= NORM;
                end
                NORM: begin
`ifdef FLOAT_MUL_SPECIAL_EN
                    C <= spec_r ? spec_c : rounded;
`else
                    C <= rounded;
`endif
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_mul_seq.sv
// Self-checking bench for float_mul_seq: reference FP32 model plus directed vectors.
// Honours FLOAT_MUL_SPECIAL_EN in the same way as the design.
module tb_float_mul_seq;

    localparam int unsigned BPC = 1;
    localparam int unsigned NCYC = 24 / BPC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, C;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [31:0] A4, B4, C4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float_mul_seq #(.DATA_WIDTH(32), .BITS_PER_CYCLE(BPC)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .C(C)
    );

    float_mul_seq #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(A4), .B(B4), .out_valid(out_valid4), .out_ready(out_ready4), .C(C4)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference product from real-valued rules: integer significand product,
    // rounding by comparing the discarded remainder against half an ulp.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned ma, mb, prod, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
`ifdef FLOAT_MUL_SPECIAL_EN
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 || eb == 255) begin
            if (ea == 0 || eb == 0) return 32'h7FC00000;
            return {s, 8'hFF, 23'h0};
        end
`endif
        if (ea == 0 || eb == 0) return {s, 31'h0};
        ma   = 64'(a[22:0]) + (64'd1 << 23);
        mb   = 64'(b[22:0]) + (64'd1 << 23);
        prod = ma * mb;
        e    = ea + eb - 127;
        if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end else begin
            sh = 23;
        end
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), 23'(q)};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef FLOAT_MUL_SPECIAL_EN
        if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
            return 1;
`endif
        return int'(NCYC) + 1;
    endfunction

    // Per-cycle compare against a one-deep transaction model.
    bit          m_busy = 1'b0;
    logic [31:0] m_c;
    int          m_ready_cyc;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_C", C, 32'h0);
            m_busy = 1'b0;
        end else begin
            check("mon_in_ready", 32'(in_ready), 32'(!m_busy));
            check("mon_out_valid", 32'(out_valid), 32'(m_busy && (cyc >= m_ready_cyc)));
            if (out_valid && m_busy) check("mon_C", C, m_c);
            if (!m_busy && in_valid) begin
                m_busy      = 1'b1;
                m_c         = ref_mul(A, B);
                m_ready_cyc = cyc + 1 + ref_lat(A, B);
            end else if (m_busy && out_valid && out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic wait_in_ready(input string nm);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check({nm, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out_valid(input string nm);
        int t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) check({nm, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input string nm);
        wait_in_ready(nm);
        in_valid = 1'b1;
        A = a;
        B = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expc,
                         input string nm);
        accept_op(a, b, nm);
        wait_out_valid(nm);
        check(nm, C, expc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    localparam int NV = 11;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vc [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; A4 = '0; B4 = '0;

        va = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h80000000,
               32'h3F800000, 32'h3F800001, 32'h3F800003, 32'h7F7FFFFF, 32'h7F7FFFFF};
        vb = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h40000000,
               32'hBF800000, 32'h3FC00000, 32'h3FC00000, 32'h3F800000, 32'h40000000};
        vc = '{32'h40C00000, 32'h40100000, 32'h3F800002, 32'h7F800000, 32'h00000000, 32'h80000000,
               32'hBF800000, 32'h3FC00002, 32'h3FC00004, 32'h7F7FFFFF, 32'h7F800000};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("model_2x3", ref_mul(32'h40000000, 32'h40400000), 32'h40C00000);
        check("model_rne_sticky", ref_mul(32'h3F800001, 32'h3F800001), 32'h3F800002);
        check("model_tie_even", ref_mul(32'h3F800003, 32'h3FC00000), 32'h3FC00004);

        for (int i = 0; i < NV; i++) do_op(va[i], vb[i], vc[i], $sformatf("vec%0d", i));

`ifdef FLOAT_MUL_SPECIAL_EN
        do_op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, "sp_nan");
        do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, "sp_inf_x_zero");
        do_op(32'hFF800000, 32'h40000000, 32'hFF800000, "sp_neg_inf");
`endif

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            do_op(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
        end

        // Backpressure: result held while junk in_valid pulses are ignored.
        accept_op(32'h40000000, 32'h40400000, "bp");
        wait_out_valid("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_C_hold", C, 32'h40C00000);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            in_valid = (i % 2 == 0);
            A = 32'h3F800000;
            B = 32'h3F800000;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_retire_valid", 32'(out_valid), 32'd0);
        check("bp_retire_ready", 32'(in_ready), 32'd1);
        do_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, "bp_next");

        // Reset in the middle of the multiply phase.
        accept_op(32'h40000000, 32'h40400000, "rst");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_C", C, 32'h0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_post_ready", 32'(in_ready), 32'd1);
        check("rst_post_valid", 32'(out_valid), 32'd0);
        check("rst_post_C", C, 32'h0);
        do_op(32'h3F800001, 32'h3F800001, 32'h3F800002, "rst_fresh");

        // Radix-16 instance: same product, N+1 = 7 cycle latency.
        in_valid4 = 1'b1;
        A4 = 32'h3FC00000;
        B4 = 32'h3FC00000;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bpc4_latency", 32'(lat), 32'd7);
        check("bpc4_C", C4, 32'h40100000);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check("bpc4_retire", 32'(out_valid4), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
